// File: rtl/mem_arb_pkg.sv
// Shared definitions for the dual-core memory arbiter.
//   - arb_state_t : arbiter FSM states
//   - DATA_W_DEF / ADDR_W_DEF : default memory data / address widths
//   - CORE0 / CORE1 : grant encodings (index of the served core)
package mem_arb_pkg;

    localparam int DATA_W_DEF = 8;
    localparam int ADDR_W_DEF = 16;

    typedef enum logic [1:0] {
        IDLE  = 2'd0,
        ISSUE = 2'd1,
        WAIT  = 2'd2,
        DONE  = 2'd3
    } arb_state_t;

    localparam logic CORE0 = 1'b0;
    localparam logic CORE1 = 1'b1;

endpackage

// File: rtl/rr_arbiter2.sv
// Combinational two-way round-robin pick.
// Ports:
//   req[1:0]   in   request per core (bit 0 = core 0)
//   last_grant in   core served by the previous grant
//   gnt_valid  out  at least one request present
//   gnt        out  core to serve (CORE0/CORE1); on a tie, the core that
//                   was not served last
module rr_arbiter2
    import mem_arb_pkg::*;
(
    input  logic [1:0] req,
    input  logic       last_grant,
    output logic       gnt_valid,
    output logic       gnt
);

    always_comb begin
        gnt_valid = |req;
        gnt       = CORE0;
        unique case (req)
            2'b01:   gnt = CORE0;
            2'b10:   gnt = CORE1;
            2'b11:   gnt = (last_grant == CORE0) ? CORE1 : CORE0;
            default: gnt = CORE0;
        endcase
    end

endmodule

// File: rtl/dual_mem_arbiter.sv
// Round-robin arbiter sharing one single-port byte memory between two cores.
// Each access: grant in IDLE, one-cycle strobe in ISSUE, READ_LAT-cycle wait
// for reads, one-cycle ready pulse in DONE.
//
// state | meaning
// IDLE  | no access in flight; pick a requester
// ISSUE | drive latched addr/data and one strobe for one cycle
// WAIT  | read in flight; count down READ_LAT, sample data on last cycle
// DONE  | pulse ready to the granted core
//
// Ports:
//   clk, reset (async, active low)
//   c0_/c1_ memread, memwrite, addr, writedata  in   core requests
//   c0_/c1_ ready                              out  completion pulse
//   c0_/c1_ memdata                            out  registered read byte
//   mem_addr, mem_wdata, mem_we, mem_re        out  shared memory port
//   mem_rdata                                  in   memory read data
// Optional build macro DUAL_MEM_ARB_STATS_EN adds stat_c0_grants,
// stat_c1_grants and stat_conflicts (16-bit wrapping counters).
module dual_mem_arbiter
    import mem_arb_pkg::*;
#(
    parameter int DATA_W   = DATA_W_DEF,
    parameter int ADDR_W   = ADDR_W_DEF,
    parameter int READ_LAT = 1
)(
    input  logic              clk,
    input  logic              reset,
    input  logic              c0_memread,
    input  logic              c0_memwrite,
    input  logic [ADDR_W-1:0] c0_addr,
    input  logic [DATA_W-1:0] c0_writedata,
    output logic              c0_ready,
    output logic [DATA_W-1:0] c0_memdata,
    input  logic              c1_memread,
    input  logic              c1_memwrite,
    input  logic [ADDR_W-1:0] c1_addr,
    input  logic [DATA_W-1:0] c1_writedata,
    output logic              c1_ready,
    output logic [DATA_W-1:0] c1_memdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic [DATA_W-1:0] mem_wdata,
    output logic              mem_we,
    output logic              mem_re,
    input  logic [DATA_W-1:0] mem_rdata
`ifdef DUAL_MEM_ARB_STATS_EN
    ,
    output logic [15:0]       stat_c0_grants,
    output logic [15:0]       stat_c1_grants,
    output logic [15:0]       stat_conflicts
`endif
);

    localparam logic [2:0] CNT_INIT = 3'(READ_LAT);

    arb_state_t        state_q, state_d;
    logic [1:0]        req;
    logic              arb_valid, arb_gnt;
    logic              gnt_q, last_grant_q, is_write_q;
    logic [ADDR_W-1:0] addr_q;
    logic [DATA_W-1:0] wdata_q;
    logic [2:0]        cnt_q;
    logic [DATA_W-1:0] c0_md_q, c1_md_q;
    logic              grant_en, cnt_load, cnt_dec, rd_sample;

    assign req = {c1_memread | c1_memwrite, c0_memread | c0_memwrite};

    rr_arbiter2 u_rr (
        .req        (req),
        .last_grant (last_grant_q),
        .gnt_valid  (arb_valid),
        .gnt        (arb_gnt)
    );

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) state_q <= IDLE;
        else        state_q <= state_d;
    end

    // Strobes and ready decode straight from state so an async reset
    // removes them in the same instant.
    always_comb begin
        state_d   = state_q;
        grant_en  = 1'b0;
        cnt_load  = 1'b0;
        cnt_dec   = 1'b0;
        rd_sample = 1'b0;
        mem_addr  = '0;
        mem_wdata = '0;
        mem_we    = 1'b0;
        mem_re    = 1'b0;
        c0_ready  = 1'b0;
        c1_ready  = 1'b0;
        unique case (state_q)
            IDLE: begin
                if (arb_valid) begin
                    grant_en = 1'b1;
                    state_d  = ISSUE;
                end
            end
            ISSUE: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                mem_we    = is_write_q;
                mem_re    = !is_write_q;
                if (is_write_q) begin
                    state_d = DONE;
                end else begin
                    cnt_load = 1'b1;
                    state_d  = WAIT;
                end
            end
            WAIT: begin
                mem_addr  = addr_q;
                mem_wdata = wdata_q;
                cnt_dec   = 1'b1;
                if (cnt_q == 3'd1) begin
                    rd_sample = 1'b1;
                    state_d   = DONE;
                end
            end
            DONE: begin
                c0_ready = (gnt_q == CORE0);
                c1_ready = (gnt_q == CORE1);
                state_d  = IDLE;
            end
            default: state_d = IDLE;
        endcase
    end

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            gnt_q        <= CORE0;
            last_grant_q <= CORE1;
            is_write_q   <= 1'b0;
            addr_q       <= '0;
            wdata_q      <= '0;
            cnt_q        <= '0;
            c0_md_q      <= '0;
            c1_md_q      <= '0;
        end else begin
            if (grant_en) begin
                gnt_q        <= arb_gnt;
                last_grant_q <= arb_gnt;
                if (arb_gnt == CORE0) begin
                    addr_q     <= c0_addr;
                    wdata_q    <= c0_writedata;
                    is_write_q <= c0_memwrite;
                end else begin
                    addr_q     <= c1_addr;
                    wdata_q    <= c1_writedata;
                    is_write_q <= c1_memwrite;
                end
            end
            if (cnt_load)     cnt_q <= CNT_INIT;
            else if (cnt_dec) cnt_q <= cnt_q - 3'd1;
            if (rd_sample) begin
                if (gnt_q == CORE0) c0_md_q <= mem_rdata;
                else                c1_md_q <= mem_rdata;
            end
        end
    end

    assign c0_memdata = c0_md_q;
    assign c1_memdata = c1_md_q;

`ifdef DUAL_MEM_ARB_STATS_EN
    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            stat_c0_grants <= '0;
            stat_c1_grants <= '0;
            stat_conflicts <= '0;
        end else begin
            if (grant_en) begin
                if (arb_gnt == CORE0) stat_c0_grants <= stat_c0_grants + 16'd1;
                else                  stat_c1_grants <= stat_c1_grants + 16'd1;
            end
            if (state_q == IDLE && req == 2'b11)
                stat_conflicts <= stat_conflicts + 16'd1;
        end
    end
`endif

endmodule
